// File: rtl/br_buf_ctrl.sv
// Sequencing controller for the branch ROB-ID ring buffer: dispatch gating,
// commit reads, occupancy tracking across misprediction flushes and clear drains.
`ifndef RobDepth
`define RobDepth 64
`endif

module br_buf_ctrl #(
  parameter  int DEPTH     = 16,
  parameter  int ROB_DEPTH = `RobDepth,
  localparam int ADDR      = $clog2(DEPTH),
  localparam int ROB       = $clog2(ROB_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dec_br_,
  input  logic [ROB-1:0]  dec_rob_id,
  output logic            dec_stall,
  input  logic            com_br_,
  input  logic            wb_flush_,
  input  logic [ADDR-1:0] wb_idx,
  input  logic            clr_req,
  output logic            buf_we_,
  output logic [ROB-1:0]  buf_wd,
  output logic            buf_re_,
  output logic [ADDR:0]   count,
  output logic            empty,
  output logic            full,
  output logic            clr_done,
  output logic            err
);

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN} state_e;

  localparam logic [ADDR:0] FULL_CNT = (ADDR+1)'(DEPTH);

  state_e          state_q, state_d;
  logic [ADDR-1:0] tail_q, tail_d;
  logic [ADDR:0]   count_q, count_d;
  logic            err_q, err_d;
  logic            rd, wr, flush_tk;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign count     = count_q;
  assign err       = err_q;
  assign clr_done  = (state_q == DRAIN) && empty;

  assign dec_stall = reset | (state_q != RUN) | full | ~wb_flush_ | clr_req;
  assign buf_we_   = dec_br_ | dec_stall;
  assign buf_wd    = dec_rob_id;
  assign buf_re_   = ~rd;

  // Drain reads unconditionally until empty; RUN and FLUSH read only on commit.
  assign rd       = ~empty & ((state_q == DRAIN) | ~com_br_);
  assign wr       = ~buf_we_;
  assign flush_tk = (state_q == RUN) & ~wb_flush_ & ~clr_req;

  always_comb begin
    state_d = state_q;
    tail_d  = tail_q + ADDR'(rd);
    err_d   = err_q | ((state_q != DRAIN) & ~com_br_ & empty);
    // Flush keeps entries from tail through wb_idx inclusive; mod-DEPTH math covers wrap.
    if (flush_tk)
      count_d = {1'b0, wb_idx - tail_q + ADDR'(1) - ADDR'(rd)};
    else
      count_d = count_q + (ADDR+1)'(wr) - (ADDR+1)'(rd);
    case (state_q)
      RUN: begin
        if (clr_req)         state_d = DRAIN;
        else if (!wb_flush_) state_d = FLUSH;
      end
      FLUSH:   state_d = RUN;
      DRAIN:   if (empty) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_br_buf_ctrl.sv
// Scoreboard bench for br_buf_ctrl: a behavioural model predicts strobes and
// next-cycle occupancy; registered expectations are queued and checked a cycle later.
module tb_br_buf_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       dec_br_, com_br_, wb_flush_, clr_req;
  logic [5:0] dec_rob_id;
  logic [3:0] wb_idx;
  logic       dec_stall, buf_we_, buf_re_, empty, full, clr_done, err;
  logic [5:0] buf_wd;
  logic [4:0] count;

  br_buf_ctrl dut (
    .clk(clk), .reset(reset), .dec_br_(dec_br_), .dec_rob_id(dec_rob_id),
    .dec_stall(dec_stall), .com_br_(com_br_), .wb_flush_(wb_flush_),
    .wb_idx(wb_idx), .clr_req(clr_req), .buf_we_(buf_we_), .buf_wd(buf_wd),
    .buf_re_(buf_re_), .count(count), .empty(empty), .full(full),
    .clr_done(clr_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int emp;
    int ful;
    int er;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // reference model: ms 0=RUN 1=FLUSH 2=DRAIN
  int   ms, mtail, mcnt, merr;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d @%0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ms = 0; mtail = 0; mcnt = 0; merr = 0;
  endtask

  // One cycle: drive (active-high args), check comb outputs, queue next-state, check it.
  task automatic step(input bit br, input bit com, input bit fl, input bit clr,
                      input int rob = 0, input int idx = 0);
    int   stall, wr, rd, ncnt, nst, x;
    exp_t e;
    dec_br_    = !br;
    com_br_    = !com;
    wb_flush_  = !fl;
    clr_req    = clr;
    dec_rob_id = rob[5:0];
    wb_idx     = idx[3:0];
    #2;
    stall = (ms != 0 || mcnt == 16 || fl || clr) ? 1 : 0;
    wr    = (br && !stall) ? 1 : 0;
    rd    = (mcnt != 0 && (ms == 2 || com)) ? 1 : 0;
    chk("dec_stall", dec_stall, stall);
    chk("buf_we_", buf_we_, 1 - wr);
    chk("buf_re_", buf_re_, 1 - rd);
    chk("clr_done", clr_done, (ms == 2 && mcnt == 0) ? 1 : 0);
    if (wr) chk("buf_wd", buf_wd, rob);
    if (ms != 2 && com && mcnt == 0) merr = 1;
    if (ms == 0 && fl && !clr) begin
      x    = (idx - mtail + 16) % 16;
      ncnt = (x + 1 - rd + 16) % 16;
    end else
      ncnt = mcnt + wr - rd;
    case (ms)
      0:       nst = clr ? 2 : (fl ? 1 : 0);
      1:       nst = 0;
      default: nst = (mcnt == 0) ? 0 : 2;
    endcase
    mtail = (mtail + rd) % 16;
    mcnt  = ncnt;
    ms    = nst;
    e.cnt = mcnt; e.emp = (mcnt == 0); e.ful = (mcnt == 16); e.er = merr;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("count", count, e.cnt);
    chk("empty", empty, e.emp);
    chk("full", full, e.ful);
    chk("err", err, e.er);
  endtask

  initial begin
    reset = 1'b1; dec_br_ = 1'b1; com_br_ = 1'b1; wb_flush_ = 1'b1;
    clr_req = 1'b0; dec_rob_id = '0; wb_idx = '0;
    model_reset();
    #3;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_re_", buf_re_, 1);
    chk("rst_we_", buf_we_, 1);
    chk("rst_stall", dec_stall, 1);
    chk("rst_err", err, 0);
    chk("rst_clr_done", clr_done, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // fill to full, then an extra dispatch must stall
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, i);
    chk("fill_count", count, 16);
    chk("fill_full", full, 1);
    step(1, 0, 0, 0, 16);

    // commit + dispatch at full: read only; then both together hold count
    step(1, 1, 0, 0, 17);
    chk("full_commit_cnt", count, 15);
    step(1, 1, 0, 0, 18);
    chk("both_cnt", count, 15);

    // move tail to 14 with 6 entries, then flush with wrap (wb_idx=1)
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 20 + i);
    chk("pre_flush_cnt", count, 6);
    step(1, 0, 1, 0, 30, 1);
    chk("wrap_flush_cnt", count, 4);
    step(1, 0, 0, 0, 31);
    step(1, 0, 0, 0, 32);
    chk("post_flush_cnt", count, 5);

    // tail to 5 with 2 entries, then flush with commit at wb_idx=5
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 40 + i);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
    chk("pre_fc_cnt", count, 2);
    step(0, 1, 1, 0, 0, 5);
    chk("flush_commit_cnt", count, 0);
    chk("flush_commit_empty", empty, 1);
    step(0, 0, 0, 0);

    // commit while empty -> sticky err
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("err_sticky", err, 1);

    // drain of 3 with a simultaneous flush and flushes during the drain
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 50 + i);
    step(1, 0, 1, 1, 55, 9);
    chk("drain_entry_cnt", count, 3);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 56, 2);
    chk("drain_cnt0", count, 0);
    step(0, 0, 0, 0);
    chk("drain_back_run", dec_stall, 0);

    // reset mid-drain
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 60 + i);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    reset = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_clr_done", clr_done, 0);
    chk("mid_rst_stall", dec_stall, 1);
    chk("mid_rst_re_", buf_re_, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    // empty drain: clr_done the cycle after clr_req, then normal dispatch
    step(0, 0, 0, 1);
    step(1, 0, 0, 0, 7);
    step(1, 0, 0, 0, 8);
    chk("final_cnt", count, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
